// File: rtl/port_match_controller.sv
// Port-match controller: steps a packet into its port window, lets the comparator bank settle, and
// reports the lowest enabled matching entry. Optional stats counters are enabled by PORT_MATCH_STATS_EN.
module port_match_controller #(
    parameter int NUM_PORTS = 4,
    parameter int WIN_START = 8,
    parameter int WIN_LEN   = 2,
    parameter int COMP_LAT  = 2,
    localparam int AW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_wr_en,
    input  logic [AW-1:0]           cfg_addr,
    input  logic [16:0]             cfg_data,
    output logic                    cfg_rdy,
    input  logic                    pkt_start,
    input  logic                    pkt_end,
    input  logic                    word_valid,
    output logic [NUM_PORTS*16-1:0] flagged_ports,
    output logic                    comp_clear,
    input  logic [NUM_PORTS-1:0]    comp_match,
    output logic                    result_valid,
    output logic                    result_hit,
    output logic [AW-1:0]           result_idx,
    output logic                    result_short,
    output logic                    result_err,
    output logic                    busy
`ifdef PORT_MATCH_STATS_EN
    ,
    output logic [15:0]             pkt_count,
    output logic [15:0]             hit_count
`endif
);

    localparam int DW = (COMP_LAT > 1) ? $clog2(COMP_LAT) : 1;

    typedef enum logic [2:0] {IDLE, PRE, WINDOW, DRAIN, REPORT} state_t;

    // With WIN_START == 1 the first word is already the last pre-window word.
    localparam state_t FIRST_STATE = (WIN_START == 1) ? WINDOW : PRE;

    state_t               r_state;
    logic [7:0]           r_cnt;
    logic [3:0]           r_wcnt;
    logic [DW-1:0]        r_dcnt;
    logic [15:0]          r_port [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_en;
    logic                 r_valid;
    logic                 r_hit;
    logic                 r_short;
    logic                 r_err;
    logic [AW-1:0]        r_idx;

    logic                 w_start;
    logic                 w_end;
    logic                 w_cfg_wr;
    logic                 w_hit;
    logic [NUM_PORTS-1:0] w_hit_vec;
    logic [AW-1:0]        w_hit_idx;
    logic [7:0]           w_cnt_inc;

    assign w_start   = pkt_start & word_valid;
    assign w_end     = pkt_end & word_valid;
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
    assign w_cfg_wr  = cfg_wr_en && (r_state == IDLE) && (int'(cfg_addr) < NUM_PORTS);

    always_comb begin
        w_hit_vec = comp_match & r_en;
        w_hit     = |w_hit_vec;
        w_hit_idx = '0;
        for (int unsigned i = NUM_PORTS; i > 0; i--) begin
            if (w_hit_vec[i-1]) w_hit_idx = AW'(i - 1);
        end
    end

    always_comb begin
        flagged_ports = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            flagged_ports[16*i +: 16] = r_en[i] ? r_port[i] : 16'h0000;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en <= '0;
            for (int unsigned i = 0; i < NUM_PORTS; i++) r_port[i] <= '0;
        end else if (w_cfg_wr) begin
            r_port[cfg_addr] <= cfg_data[15:0];
            r_en[cfg_addr]   <= cfg_data[16];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_wcnt  <= '0;
            r_dcnt  <= '0;
            r_valid <= 1'b0;
            r_hit   <= 1'b0;
            r_idx   <= '0;
            r_short <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_cnt  <= '0;
                    r_wcnt <= '0;
                    r_dcnt <= '0;
                    if (w_end && w_start) begin
                        r_state <= REPORT;
                        r_valid <= 1'b1;
                        r_hit   <= 1'b0;
                        r_idx   <= '0;
                        r_short <= 1'b1;
                        r_err   <= 1'b0;
                    end else if (w_start) begin
                        r_cnt   <= 8'd1;
                        r_state <= FIRST_STATE;
                    end
                end
                PRE, WINDOW: begin
                    if (w_end) begin
                        r_state <= REPORT;
                        r_valid <= 1'b1;
                        r_hit   <= 1'b0;
                        r_idx   <= '0;
                        r_short <= 1'b1;
                        r_err   <= 1'b0;
                    end else if (w_start) begin
                        r_cnt   <= 8'd1;
                        r_wcnt  <= '0;
                        r_dcnt  <= '0;
                        r_state <= FIRST_STATE;
                    end else if (r_state == WINDOW && !word_valid) begin
                        r_state <= REPORT;
                        r_valid <= 1'b1;
                        r_hit   <= 1'b0;
                        r_idx   <= '0;
                        r_short <= 1'b0;
                        r_err   <= 1'b1;
                    end else if (word_valid) begin
                        r_cnt <= w_cnt_inc;
                        if (r_state == PRE) begin
                            if (r_cnt == 8'(WIN_START - 1)) r_state <= WINDOW;
                        end else if (r_wcnt == 4'(WIN_LEN - 1)) begin
                            r_dcnt  <= '0;
                            r_state <= DRAIN;
                        end else begin
                            r_wcnt <= r_wcnt + 4'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_start && pkt_end) begin
                        r_state <= REPORT;
                        r_valid <= 1'b1;
                        r_hit   <= 1'b0;
                        r_idx   <= '0;
                        r_short <= 1'b1;
                        r_err   <= 1'b0;
                    end else if (w_start) begin
                        r_cnt   <= 8'd1;
                        r_wcnt  <= '0;
                        r_dcnt  <= '0;
                        r_state <= FIRST_STATE;
                    end else if (r_dcnt == DW'(COMP_LAT - 1)) begin
                        r_state <= REPORT;
                        r_valid <= 1'b1;
                        r_hit   <= w_hit;
                        r_idx   <= w_hit_idx;
                        r_short <= 1'b0;
                        r_err   <= 1'b0;
                    end else begin
                        r_dcnt <= r_dcnt + DW'(1);
                    end
                end
                REPORT: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy         = (r_state != IDLE);
    assign cfg_rdy      = (r_state == IDLE);
    assign comp_clear   = (r_state == IDLE) || (r_state == PRE) || (r_state == REPORT);
    assign result_valid = r_valid;
    assign result_hit   = r_hit;
    assign result_idx   = r_idx;
    assign result_short = r_short;
    assign result_err   = r_err;

`ifdef PORT_MATCH_STATS_EN
    logic [15:0] r_pkt_cnt;
    logic [15:0] r_hit_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt <= '0;
            r_hit_cnt <= '0;
        end else if (r_valid) begin
            if (r_pkt_cnt != 16'hFFFF) r_pkt_cnt <= r_pkt_cnt + 16'd1;
            if (r_hit && r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
        end
    end

    assign pkt_count = r_pkt_cnt;
    assign hit_count = r_hit_cnt;
`endif

endmodule

// File: tb/tb_port_match_controller.sv
// Bench for port_match_controller: packet-level model checked every cycle, plus directed
// scenarios with hand-computed results and latencies.
module tb_port_match_controller;

    localparam int NP = 4;
    localparam int WS = 8;
    localparam int WL = 2;
    localparam int CL = 2;
    localparam int AW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_wr_en = 1'b0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [16:0]       cfg_data = '0;
    logic              cfg_rdy;
    logic              pkt_start = 1'b0;
    logic              pkt_end = 1'b0;
    logic              word_valid = 1'b0;
    logic [NP*16-1:0]  flagged_ports;
    logic              comp_clear;
    logic [NP-1:0]     comp_match = '0;
    logic              result_valid;
    logic              result_hit;
    logic [AW-1:0]     result_idx;
    logic              result_short;
    logic              result_err;
    logic              busy;
`ifdef PORT_MATCH_STATS_EN
    logic [15:0]       pkt_count;
    logic [15:0]       hit_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int tick  = 0;

    always #5 clk = ~clk;

    port_match_controller #(
        .NUM_PORTS(NP),
        .WIN_START(WS),
        .WIN_LEN(WL),
        .COMP_LAT(CL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_wr_en(cfg_wr_en),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .cfg_rdy(cfg_rdy),
        .pkt_start(pkt_start),
        .pkt_end(pkt_end),
        .word_valid(word_valid),
        .flagged_ports(flagged_ports),
        .comp_clear(comp_clear),
        .comp_match(comp_match),
        .result_valid(result_valid),
        .result_hit(result_hit),
        .result_idx(result_idx),
        .result_short(result_short),
        .result_err(result_err),
        .busy(busy)
`ifdef PORT_MATCH_STATS_EN
        ,
        .pkt_count(pkt_count),
        .hit_count(hit_count)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packet-level model: tracks words seen and drain cycles, not the DUT's state encoding.
    logic [15:0]   m_port [NP];
    logic [NP-1:0] m_en = '0;
    bit            m_busy = 1'b0;
    bit            m_rep = 1'b0;
    int            m_n = 0;
    int            m_d = 0;
    logic          m_hit = 1'b0;
    logic          m_short = 1'b0;
    logic          m_err = 1'b0;
    logic [AW-1:0] m_idx = '0;
    int            m_pkts = 0;
    int            m_hits = 0;

    always @(posedge clk or posedge rst) begin : model
        bit            busy_n, rep_n;
        int            n_n, d_n, pk_n, hk_n;
        logic          hit_n, short_n, err_n;
        logic [AW-1:0] idx_n;
        if (rst) begin
            for (int i = 0; i < NP; i++) m_port[i] <= '0;
            m_en <= '0; m_busy <= 0; m_rep <= 0; m_n <= 0; m_d <= 0;
            m_hit <= 0; m_short <= 0; m_err <= 0; m_idx <= '0;
            m_pkts <= 0; m_hits <= 0;
        end else begin
            busy_n = m_busy; rep_n = 0; n_n = m_n; d_n = m_d;
            hit_n = m_hit; short_n = m_short; err_n = m_err; idx_n = m_idx;
            pk_n = m_pkts; hk_n = m_hits;
            if (m_rep) begin
                busy_n = 0;
                if (pk_n < 65535) pk_n++;
                if (m_hit && hk_n < 65535) hk_n++;
            end else if (!m_busy) begin
                if (cfg_wr_en && int'(cfg_addr) < NP) begin
                    m_port[cfg_addr] <= cfg_data[15:0];
                    m_en[cfg_addr]   <= cfg_data[16];
                end
                if (word_valid && pkt_start) begin
                    busy_n = 1; n_n = 1; d_n = 0;
                    if (pkt_end) begin
                        rep_n = 1; hit_n = 0; idx_n = '0; short_n = 1; err_n = 0;
                    end
                end
            end else if (word_valid && pkt_start) begin
                if (pkt_end) begin
                    rep_n = 1; hit_n = 0; idx_n = '0; short_n = 1; err_n = 0;
                end else begin
                    n_n = 1; d_n = 0;
                end
            end else if (m_n >= WS + WL) begin
                d_n = m_d + 1;
                if (d_n == CL) begin
                    rep_n = 1; hit_n = 0; idx_n = '0; short_n = 0; err_n = 0;
                    for (int i = 0; i < NP; i++) begin
                        if (!hit_n && comp_match[i] && m_en[i]) begin
                            hit_n = 1; idx_n = AW'(i);
                        end
                    end
                end
            end else if (word_valid && pkt_end) begin
                rep_n = 1; hit_n = 0; idx_n = '0; short_n = 1; err_n = 0;
            end else if (m_n >= WS && !word_valid) begin
                rep_n = 1; hit_n = 0; idx_n = '0; short_n = 0; err_n = 1;
            end else if (word_valid) begin
                n_n = m_n + 1;
            end
            m_busy <= busy_n; m_rep <= rep_n; m_n <= n_n; m_d <= d_n;
            m_hit <= hit_n; m_short <= short_n; m_err <= err_n; m_idx <= idx_n;
            m_pkts <= pk_n; m_hits <= hk_n;
        end
    end

    always @(negedge clk) begin : compare
        logic [NP*16-1:0] ef;
        ef = '0;
        for (int i = 0; i < NP; i++) if (m_en[i]) ef[16*i +: 16] = m_port[i];
        chk("busy", busy, m_busy);
        chk("cfg_rdy", cfg_rdy, !m_busy);
        chk("comp_clear", comp_clear, !m_busy || m_rep || m_n < WS);
        chk("result_valid", result_valid, m_rep);
        chk("result_hit", result_hit, m_hit);
        chk("result_idx", result_idx, m_idx);
        chk("result_short", result_short, m_short);
        chk("result_err", result_err, m_err);
        chk("flagged_ports", flagged_ports, ef);
`ifdef PORT_MATCH_STATS_EN
        chk("pkt_count", pkt_count, 16'(m_pkts));
        chk("hit_count", hit_count, 16'(m_hits));
`endif
    end

    task automatic cyc(input logic wv, input logic ps, input logic pe, input logic [NP-1:0] cm);
        word_valid = wv; pkt_start = ps; pkt_end = pe; comp_match = cm;
        @(posedge clk); #1;
        tick++;
    endtask

    task automatic cfg_write(input int a, input logic [16:0] d);
        cfg_wr_en = 1'b1; cfg_addr = AW'(a); cfg_data = d;
        cyc(1'b0, 1'b0, 1'b0, '0);
        cfg_wr_en = 1'b0;
    endtask

    task automatic send(input int len, input logic [NP-1:0] cm);
        for (int k = 0; k < len; k++) cyc(1'b1, k == 0, k == len - 1, cm);
    endtask

    task automatic wait_result(input string name, input int t0, input int lat,
                               input logic hit, input int idx, input logic sh, input logic er);
        for (int i = 0; i < 20 && !result_valid; i++) cyc(1'b0, 1'b0, 1'b0, comp_match);
        chk({name, "_seen"}, result_valid, 1'b1);
        chk({name, "_lat"}, tick - t0, lat);
        chk({name, "_hit"}, result_hit, hit);
        chk({name, "_idx"}, result_idx, idx);
        chk({name, "_short"}, result_short, sh);
        chk({name, "_err"}, result_err, er);
    endtask

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flagged", flagged_ports, '0);
        chk("rst_rdy", cfg_rdy, 1'b1);
        chk("rst_clear", comp_clear, 1'b1);
        chk("rst_valid", result_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;

        cfg_write(1, {1'b1, 16'h0050});
        chk("entry1", flagged_ports[31:16], 16'h0050);
        t0 = tick; send(12, 4'b0010);
        wait_result("basic", t0, 12, 1'b1, 1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("basic_idle", busy, 1'b0);

        cfg_write(0, {1'b1, 16'h1111});
        cfg_write(2, {1'b1, 16'h2222});
        t0 = tick; send(12, 4'b0101);
        wait_result("prio", t0, 12, 1'b1, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0);

        cfg_write(1, {1'b0, 16'h0050});
        chk("entry1_off", flagged_ports[31:16], 16'h0000);
        t0 = tick; send(12, 4'b1010);
        wait_result("disabled", t0, 12, 1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        t0 = tick; send(12, 4'b1110);
        wait_result("idx2", t0, 12, 1'b1, 2, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0);

        t0 = tick; send(6, 4'b0101);
        wait_result("short", t0, 6, 1'b0, 0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk("short_idle", busy, 1'b0);

        t0 = tick;
        for (int k = 0; k < 8; k++) cyc(1'b1, k == 0, 1'b0, '1);
        cyc(1'b0, 1'b0, 1'b0, '1);
        wait_result("gap", t0, 9, 1'b0, 0, 1'b0, 1'b1);
        chk("gap_clear", comp_clear, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, '0);

        t0 = tick;
        for (int k = 0; k < 8; k++) cyc(1'b1, k == 0, 1'b0, '0);
        cfg_wr_en = 1'b1; cfg_addr = 2'd3; cfg_data = {1'b1, 16'hBEEF};
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("win_rdy", cfg_rdy, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        cfg_wr_en = 1'b0;
        chk("win_entry3", flagged_ports[63:48], 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b1, '0);
        wait_result("win_cfg", t0, 12, 1'b0, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0);

        for (int k = 0; k < 9; k++) cyc(1'b1, k == 0, 1'b0, 4'b0001);
        t0 = tick; send(12, 4'b0100);
        wait_result("restart", t0, 12, 1'b1, 2, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0);

        t0 = tick; send(11, 4'b0001);
        wait_result("drain_end", t0, 12, 1'b1, 0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0);

        for (int k = 0; k < 10; k++) cyc(1'b1, k == 0, 1'b0, '1);
        cyc(1'b0, 1'b0, 1'b0, '1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", result_valid, 1'b0);
        chk("mid_rst_hit", result_hit, 1'b0);
        chk("mid_rst_flagged", flagged_ports, '0);
        chk("mid_rst_rdy", cfg_rdy, 1'b1);
        chk("mid_rst_clear", comp_clear, 1'b1);
`ifdef PORT_MATCH_STATS_EN
        chk("mid_rst_pkts", pkt_count, 16'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cyc(1'b0, 1'b0, 1'b0, '1);
            chk("post_rst_valid", result_valid, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
